// File: rtl/imem_arbiter.sv
// Arbitrates NUM_REQ i-cache miss ports onto one byte-serial instruction memory.
// Round-robin grant with an OS-driven priority override; one block transfer at a time.
module imem_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_read,
  input  logic [NUM_REQ*28-1:0] req_address,
  output logic [NUM_REQ-1:0]    req_busywait,
  output logic [127:0]          readdata,
  input  logic                  prio_en,
  input  logic [IDX_W-1:0]      prio_id,
  output logic                  mem_read,
  output logic [27:0]           mem_address,
  input  logic [127:0]          mem_readdata,
  input  logic                  mem_busywait
);

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned DATA_W = 128;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_SETTLE = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [IDX_W-1:0]    r_grant;
  logic [IDX_W-1:0]    r_last_grant;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_readdata;
  logic                r_mem_read;

  logic                w_any_req;
  logic                w_prio_ok;
  logic                w_rr_found;
  logic [IDX_W-1:0]    w_rr_idx;
  logic [IDX_W-1:0]    w_winner;
  logic [ADDR_W-1:0]   w_win_addr;

  // Winner selection: override if the favoured cache is requesting, else rotate from last_grant
  always_comb begin
    w_any_req  = |req_read;
    w_prio_ok  = prio_en && (32'(prio_id) < NUM_REQ) && req_read[prio_id];
    w_rr_found = 1'b0;
    w_rr_idx   = r_last_grant;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      if (!w_rr_found &&
          req_read[IDX_W'((int'(r_last_grant) + k) % int'(NUM_REQ))]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = IDX_W'((int'(r_last_grant) + k) % int'(NUM_REQ));
      end
    end
    w_winner   = w_prio_ok ? prio_id : w_rr_idx;
    w_win_addr = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_winner == IDX_W'(i)) begin
        w_win_addr = req_address[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_state_next = S_FETCH;
      S_FETCH:  if (!mem_busywait) w_state_next = S_SETTLE;
      S_SETTLE: w_state_next = S_RESP;
      S_RESP:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Grant/address latch, memory strobe and response capture
  always_ff @(posedge clock) begin
    if (reset) begin
      r_grant      <= '0;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_addr       <= '0;
      r_readdata   <= '0;
      r_mem_read   <= 1'b0;
    end else begin
      r_mem_read <= (w_state_next == S_FETCH);
      if (r_state == S_IDLE && w_any_req) begin
        r_grant <= w_winner;
        r_addr  <= w_win_addr;
      end
      if (r_state == S_SETTLE) begin
        r_readdata   <= mem_readdata;
        r_last_grant <= r_grant;
      end
    end
  end

  // A cache is released only during RESP, and only if it still requests
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_busywait[i] = req_read[i] & ~((r_state == S_RESP) && (r_grant == IDX_W'(i)));
    end
  end

  assign readdata    = r_readdata;
  assign mem_read    = r_mem_read;
  assign mem_address = r_addr;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a byte-serial memory model (16 cycles per block).
module tb_imem_arbiter;

  logic         clock = 1'b0;
  logic         reset;
  logic [1:0]   req_read;
  logic [55:0]  req_address;
  logic [1:0]   req_busywait;
  logic [127:0] readdata;
  logic         prio_en;
  logic [0:0]   prio_id;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  imem_arbiter #(.NUM_REQ(2), .IDX_W(1)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_read     (req_read),
    .req_address  (req_address),
    .req_busywait (req_busywait),
    .readdata     (readdata),
    .prio_en      (prio_en),
    .prio_id      (prio_id),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  // Block contents: address 0 holds the known first instruction word
  function automatic logic [127:0] blk(input logic [27:0] a);
    logic [31:0] w0;
    w0 = (a == 28'd0) ? 32'h3e800013 : {4'h9, a};
    return {{4'h3, a}, {4'h2, a}, {4'h1, a}, w0};
  endfunction

  // Memory: one byte per cycle while mem_read, counter wraps after 16 bytes
  logic [3:0]   m_cnt;
  logic [127:0] m_buf;
  logic [127:0] m_blk;
  assign m_blk        = blk(mem_address);
  assign mem_readdata = m_buf;
  assign mem_busywait = mem_read && (m_cnt != 4'd15);

  always_ff @(posedge clock) begin
    if (reset) begin
      m_cnt <= 4'd0;
      m_buf <= '0;
    end else if (mem_read) begin
      m_buf[{m_cnt, 3'b000} +: 8] <= m_blk[{m_cnt, 3'b000} +: 8];
      m_cnt <= m_cnt + 4'd1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full grant starting in IDLE: arbitration edge, 16 FETCH, SETTLE, RESP, back to IDLE
  task automatic fetch(input int g, input logic [27:0] a, input int drop_cyc,
                       input int chaddr_cyc, input logic [1:0] bw_resp);
    int rd_cyc;
    int bad_addr;
    rd_cyc   = 0;
    bad_addr = 0;
    tick();
    for (int k = 1; k <= 16; k++) begin
      if (mem_read) begin
        rd_cyc++;
        if (mem_address !== a) bad_addr++;
      end
      if (k == drop_cyc)   req_read[g] = 1'b0;
      if (k == chaddr_cyc) req_address[g*28 +: 28] = a ^ 28'h0ff_ffff;
      tick();
    end
    check("fetch_len", 128'(rd_cyc), 128'd16);
    check("fetch_addr_bad", 128'(bad_addr), 128'd0);
    check("settle_mread", 128'(mem_read), 128'd0);
    check("settle_bw", 128'(req_busywait), 128'(req_read));
    tick();
    check("resp_bw", 128'(req_busywait), 128'(bw_resp));
    check("resp_data", readdata, blk(a));
    tick();
    check("idle_bw", 128'(req_busywait), 128'(req_read));
  endtask

  initial begin
    reset       = 1'b1;
    req_read    = 2'b00;
    req_address = '0;
    prio_en     = 1'b0;
    prio_id     = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // T1: reset state, then a single request to address 0
    check("rst_mread", 128'(mem_read), 128'd0);
    check("rst_maddr", 128'(mem_address), 128'd0);
    check("rst_rdata", readdata, 128'd0);
    check("rst_bw", 128'(req_busywait), 128'd0);
    req_read              = 2'b01;
    req_address[27:0]     = 28'h0;
    fetch(0, 28'h0, 0, 0, 2'b00);
    check("t1_word0", 128'(readdata[31:0]), 128'h3e800013);
    req_read = 2'b00;
    tick();
    tick();
    check("t1_idle_mread", 128'(mem_read), 128'd0);

    // T2: both requesting continuously, round-robin from reset last_grant=1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_address[27:0]  = 28'h0000010;
    req_address[55:28] = 28'h0000020;
    req_read           = 2'b11;
    fetch(0, 28'h0000010, 0, 0, 2'b10);
    fetch(1, 28'h0000020, 0, 0, 2'b01);
    fetch(0, 28'h0000010, 0, 0, 2'b10);
    fetch(1, 28'h0000020, 0, 0, 2'b01);

    // T3: last_grant=1, override favours requester 1 over the round-robin choice
    prio_en = 1'b1;
    prio_id = 1'b1;
    fetch(1, 28'h0000020, 0, 0, 2'b01);
    prio_en  = 1'b0;
    prio_id  = 1'b0;
    req_read = 2'b00;
    tick();

    // T4: grantee drops its request mid-FETCH, then a fresh request to address 0
    req_read = 2'b01;
    fetch(0, 28'h0000010, 5, 0, 2'b00);
    req_address[27:0] = 28'h0;
    req_read          = 2'b01;
    fetch(0, 28'h0, 0, 0, 2'b00);
    check("t4_word0", 128'(readdata[31:0]), 128'h3e800013);
    req_read = 2'b00;
    tick();

    // T5: reset in FETCH cycle 8 drops the transfer
    req_address[27:0] = 28'h0000030;
    req_read          = 2'b01;
    tick();
    for (int k = 2; k <= 8; k++) tick();
    check("t5_mid_mread", 128'(mem_read), 128'd1);
    reset = 1'b1;
    tick();
    check("t5_rst_mread", 128'(mem_read), 128'd0);
    check("t5_rst_rdata", readdata, 128'd0);
    check("t5_rst_maddr", 128'(mem_address), 128'd0);
    reset = 1'b0;
    fetch(0, 28'h0000030, 0, 0, 2'b00);
    req_read = 2'b00;
    tick();

    // T6: requester 1 changes its address during FETCH; latched address is used
    req_address[55:28] = 28'h0000040;
    req_read           = 2'b10;
    fetch(1, 28'h0000040, 0, 3, 2'b00);
    req_read = 2'b00;
    tick();
    check("t6_hold_rdata", readdata, blk(28'h0000040));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
